sc_stream_ctrl: RTL and testbench
=================================

# sc_stream_ctrl

Frame controller that turns one signed quantized operand into a `BITSTREAM`-long stochastic bitstream containing exactly the operand's quota of ones. It accepts operands over a valid/ready handshake and sequences the data-to-quota conversion. It then spreads the ones with a phase-seeded Weyl/Bresenham accumulator and emits one bit per output handshake. It sits between the quantized-operand source and the stochastic arithmetic lanes.

## Interface
Parameters:
- `BITSTREAM`, default 64: frame length T in beats. Must be a power of two, ≥ 2.
- `QUANT`, default 8: operand width in bits. Must be ≥ 2.
- Derived widths:
  - `CW = $clog2(BITSTREAM)`: beat counter and phase width.
  - `QW = CW+1`: quota and accumulator width; holds 0..T.

Ports:
- `clk`  in  1: single clock. All state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operand offered.
- `in_ready`  out  1: controller can accept an operand.
- `in_data`  in  QUANT: signed two's-complement operand.
- `in_phase`  in  CW: initial accumulator value for the frame, used for stream decorrelation.
- `out_valid`  out  1: `out_bit` is valid.
- `out_ready`  in  1: downstream accepts the current beat.
- `out_bit`  out  1: current stream bit.
- `out_last`  out  1: current beat is beat T-1 of the frame.
- `busy`  out  1: a frame is in progress.
- `err`  out  1: sticky ones-count mismatch flag. Present only with `SC_QUOTA_CHECK_EN`.

## Operation
- Quota, computed with full-width intermediates:
  - u = in_data + 2^(QUANT-1), unsigned, range 0..2^QUANT-1.
  - quota = (u·T + 2^(QUANT-1)) >> QUANT, range 0..T.
- States: IDLE, STREAM.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid & in_ready`: latch quota, set acc = in_phase, set cnt = 0, go to STREAM.
- STREAM:
  - `out_valid`=1.
  - sum = acc + quota.
  - `out_bit` = (sum ≥ T).
  - `out_last` = (cnt == T-1).
  - On `out_valid & out_ready`: acc ← out_bit ? sum − T : sum; cnt ← cnt + 1.
  - On the last-beat handshake: go to IDLE, unless a new operand is accepted in the same cycle.
- Back-to-back frames:
  - `in_ready` = IDLE | (STREAM & out_ready & out_last).
  - An operand accepted on the last-beat handshake reloads quota/acc/cnt and remains in STREAM.
  - The next frame has no bubble beat.
- Invariant: for any in_phase < T, each frame contains exactly `quota` ones.
- `out_bit` and `out_last` are forced to 0 whenever `out_valid`=0.
- `busy` = (state == STREAM).

## Timing
- Reset values:
  - state IDLE.
  - `out_valid`, `out_bit`, `out_last`, `busy`, `err` all 0.
  - `in_ready` = 1.
  - acc, cnt, quota = 0.
- Latency: operand accepted at edge k → beat 0 valid in the cycle after edge k.
- Throughput: one frame per T cycles with `out_ready` held high.
- Stall: while `out_valid & !out_ready`, `out_bit`, `out_last`, acc and cnt hold. The bit sequence is independent of stall pattern.
- `rst` asserted mid-frame: `out_valid` drops asynchronously. The frame is abandoned and no further beats are produced. After release the block is in IDLE.
- `in_valid` while not ready: the operand is not consumed. The source holds `in_data`/`in_phase` stable until accepted.

## Configuration
- `SC_QUOTA_CHECK_EN` defined:
  - A CW+1-bit ones counter increments on each handshaked 1-beat and clears on frame load.
  - On the last-beat handshake, the counter including the current bit is compared with the latched quota. Mismatch sets `err`.
  - `err` clears only on `rst`.
- `SC_QUOTA_CHECK_EN` undefined: no counter; `err` tied to 0.

## Structure
- Shared package `sc_pkg`:
  - state enum `sc_state_e` {IDLE, STREAM}.
  - width helper functions for CW/QW.
- Sub-module: the existing combinational `QUOTA` converter, instantiated with quota width QW and fed from `in_data`. The controller registers its output on accept.

## Test plan
- T=64, QUANT=8, in_data=0, in_phase=0, out_ready=1 → 64 beats alternating 0,1,0,1…; 32 ones; `out_last` only on beat 63.
- in_data=−128 → 64 zero beats. in_data=127 → 64 one beats. `err` stays 0 in both cases.
- in_data=0, in_phase=63 → beat 0 = 1; total still 32 ones.
- Random `out_ready` stalls, in_data=−37 → bit sequence identical to the unstalled run; `out_bit`/`out_last` stable during stalls.
- Second operand held on `in_valid` during a frame → accepted on the last-beat handshake; its beat 0 appears the next cycle with `out_valid` continuously high.
- `rst` pulsed at beat 10 → `out_valid`=0 immediately, `in_ready`=1. The next frame (in_data=64) produces quota 48 ones cleanly.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and width helpers for the stochastic stream controller.
package sc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } sc_state_e;

    function automatic int sc_cw(input int bitstream);
        return $clog2(bitstream);
    endfunction

    function automatic int sc_qw(input int bitstream);
        return $clog2(bitstream) + 1;
    endfunction

endpackage

// File: rtl/sc_stream_ctrl_if.sv
// Operand/bitstream handshake bundle for sc_stream_ctrl.
interface sc_stream_ctrl_if
    import sc_pkg::*;
#(
    parameter int BITSTREAM = 64,
    parameter int QUANT     = 8
);
    localparam int CW = sc_cw(BITSTREAM);

    // Both channels are valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; a source holds its payload until then.
    logic                    in_valid;
    logic                    in_ready;
    logic signed [QUANT-1:0] in_data;
    logic [CW-1:0]           in_phase;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_bit;
    logic                    out_last;
    logic                    busy;
    logic                    err;

    modport master (
        output in_valid, in_data, in_phase, out_ready,
        input  in_ready, out_valid, out_bit, out_last, busy, err
    );

    modport slave (
        input  in_valid, in_data, in_phase, out_ready,
        output in_ready, out_valid, out_bit, out_last, busy, err
    );

endinterface

// File: rtl/sc_stream_ctrl_quota.sv
// Combinational operand-to-quota converter: round(u*T / 2^QUANT), u = offset-binary operand.
module sc_stream_ctrl_quota
    import sc_pkg::*;
#(
    parameter int BITSTREAM = 64,
    parameter int QUANT     = 8,
    parameter int QW        = sc_qw(BITSTREAM)
) (
    input  logic signed [QUANT-1:0] data,
    output logic [QW-1:0]           quota
);
    localparam int CW = sc_cw(BITSTREAM);
    localparam int PW = QUANT + CW + 1;

    logic [QUANT-1:0] u;
    logic [PW-1:0]    prod;

    // Flipping the sign bit adds 2^(QUANT-1); T is a power of two so u*T is a shift.
    assign u     = {~data[QUANT-1], data[QUANT-2:0]};
    assign prod  = (PW'(u) << CW) + (PW'(1) << (QUANT - 1));
    assign quota = QW'(prod >> QUANT);

endmodule

// File: rtl/sc_stream_ctrl.sv
// Frame controller: one operand in, BITSTREAM bits out with exactly quota ones.
// Optional SC_QUOTA_CHECK_EN adds a sticky ones-count mismatch flag on err.
module sc_stream_ctrl
    import sc_pkg::*;
#(
    parameter int BITSTREAM = 64,
    parameter int QUANT     = 8
) (
    input  logic            clk,
    input  logic            rst,
    sc_stream_ctrl_if.slave bus,
    output sc_state_e       fsm_state
);
    localparam int CW = sc_cw(BITSTREAM);
    localparam int QW = sc_qw(BITSTREAM);
    localparam logic [QW-1:0] T_Q    = QW'(BITSTREAM);
    localparam logic [CW-1:0] LAST_C = CW'(BITSTREAM - 1);

    sc_state_e     state, state_next;
    logic [QW-1:0] quota_w, quota_q;
    logic [QW-1:0] acc, sum;
    logic [CW-1:0] cnt;
    logic          stream_bit, last, accept, beat_fire;
    logic          out_valid_c, in_ready_c;

    sc_stream_ctrl_quota #(
        .BITSTREAM(BITSTREAM),
        .QUANT    (QUANT),
        .QW       (QW)
    ) u_quota (
        .data (bus.in_data),
        .quota(quota_w)
    );

    // acc < T and quota <= T, so sum never exceeds 2T-1 and fits in QW bits.
    assign sum        = acc + quota_q;
    assign stream_bit = (sum >= T_Q);
    assign last       = (cnt == LAST_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        out_valid_c = 1'b0;
        in_ready_c  = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_next = STREAM;
            end
            STREAM: begin
                out_valid_c = 1'b1;
                in_ready_c  = bus.out_ready & last;
                if (bus.out_ready && last && !bus.in_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept    = bus.in_valid & in_ready_c;
    assign beat_fire = out_valid_c & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quota_q <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else if (accept) begin
            quota_q <= quota_w;
            acc     <= {1'b0, bus.in_phase};
            cnt     <= '0;
        end else if (beat_fire) begin
            acc     <= stream_bit ? (sum - T_Q) : sum;
            cnt     <= cnt + CW'(1);
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_bit   = out_valid_c & stream_bit;
    assign bus.out_last  = out_valid_c & last;
    assign bus.busy      = (state == STREAM);
    assign fsm_state     = state;

`ifdef SC_QUOTA_CHECK_EN
    logic [QW-1:0] ones, ones_final;
    logic          err_q;

    // Includes the bit being handed over on the closing beat.
    assign ones_final = ones + QW'(stream_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones  <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept)                        ones <= '0;
            else if (beat_fire && stream_bit)  ones <= ones + QW'(1);
            if (beat_fire && last && (ones_final != quota_q)) err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_sc_stream_ctrl.sv
// Scoreboard bench for sc_stream_ctrl (T=64, QUANT=8).
module tb_sc_stream_ctrl;
    import sc_pkg::*;

    localparam int T  = 64;
    localparam int Q  = 8;
    localparam int CW = 6;

    logic      clk;
    logic      rst;
    sc_state_e fsm_state;

    sc_stream_ctrl_if #(.BITSTREAM(T), .QUANT(Q)) bus ();

    sc_stream_ctrl #(.BITSTREAM(T), .QUANT(Q)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .fsm_state(fsm_state)
    );

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_q[$];     // {last, bit}
    int         quota_q[$];

    int          stall_en = 0;
    int          beat = 0;
    int          ones = 0;
    logic        stall_prev = 1'b0;
    logic        prev_bit, prev_last;
    logic [T-1:0] cur_frame = '0;
    logic [T-1:0] last_frame = '0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int model_quota(input int d);
        int u;
        u = d + (1 << (Q - 1));
        return (u * T + (1 << (Q - 1))) >> Q;
    endfunction

    task automatic push_model(input int d, input int ph);
        int q, acc, s;
        logic b;
        q   = model_quota(d);
        acc = ph;
        quota_q.push_back(q);
        for (int i = 0; i < T; i++) begin
            s   = acc + q;
            b   = (s >= T);
            acc = b ? s - T : s;
            exp_q.push_back({(i == T - 1), b});
        end
    endtask

    // driver: out_ready
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = (stall_en != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic send(input int d, input int ph);
        int n;
        n = 0;
        bus.in_data  = Q'(d);
        bus.in_phase = CW'(ph);
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        push_model(d, ph);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("beat0_valid", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("frame_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [1:0] e;
        if (!rst) begin
            if (stall_prev) begin
                check("stall_bit", 64'(bus.out_bit), 64'(prev_bit));
                check("stall_last", 64'(bus.out_last), 64'(prev_last));
            end
            stall_prev = bus.out_valid & ~bus.out_ready;
            prev_bit   = bus.out_bit;
            prev_last  = bus.out_last;
            if (!bus.out_valid) check("idle_outs", 64'({bus.out_bit, bus.out_last}), 64'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_bit", 64'(bus.out_bit), 64'(e[0]));
                    check("beat_last", 64'(bus.out_last), 64'(e[1]));
                end
                if (beat < T) cur_frame[beat] = bus.out_bit;
                ones += int'(bus.out_bit);
                beat++;
                if (bus.out_last) begin
                    check("frame_ones", 64'(ones), 64'((quota_q.size() != 0) ? quota_q.pop_front() : -1));
                    check("frame_err", 64'(bus.err), 64'd0);
                    last_frame = cur_frame;
                    ones = 0;
                    beat = 0;
                end
            end
        end
    end

    initial begin
        logic [T-1:0] ref_frame;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_phase = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_outs", 64'({bus.out_valid, bus.out_bit, bus.out_last, bus.busy, bus.err}), 64'd0);
        check("rst_state", 64'(fsm_state), 64'(IDLE));
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(0, 0);
        wait_done();
        check("alt_pattern", 64'(last_frame), 64'hAAAA_AAAA_AAAA_AAAA);
        check("idle_busy", 64'(bus.busy), 64'd0);

        send(-128, 0);
        wait_done();
        check("all_zero", 64'(last_frame), 64'h0);
        send(127, 0);
        wait_done();
        check("all_one", 64'(last_frame), 64'hFFFF_FFFF_FFFF_FFFF);

        send(0, 63);
        wait_done();
        check("phase63_beat0", 64'(last_frame[0]), 64'd1);
        check("phase63_ones", 64'($countones(last_frame)), 64'd32);

        send(-37, 5);
        wait_done();
        ref_frame = last_frame;
        stall_en = 1;
        send(-37, 5);
        wait_done();
        stall_en = 0;
        check("stall_same_seq", 64'(last_frame), 64'(ref_frame));
        check("m37_ones", 64'($countones(last_frame)), 64'd23);

        send(20, 3);
        send(-90, 17);
        wait_done();

        send(0, 0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        quota_q.delete();
        ones = 0;
        beat = 0;
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_state", 64'(fsm_state), 64'(IDLE));
        send(64, 0);
        wait_done();
        check("q48_ones", 64'($countones(last_frame)), 64'd48);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
